// File: rtl/servo_pwm_array.sv
// rtl/servo_pwm_array.sv - NUM_CH servo PWM outputs from one frame counter, slew-limited, frame-aligned updates.
// Optional macro SERVO_STAGGER_EN offsets channel k's rise by k*STAGGER_CYC cycles.
module servo_pwm_array #(
  parameter int NUM_CH      = 4,
  parameter int ANGLE_W     = 8,
  parameter int PERIOD_CYC  = 500000,
  parameter int MIN_PULSE   = 25000,
  parameter int MAX_PULSE   = 50000,
  parameter int PULSE_LSB   = 98,
  parameter int SLEW_STEP   = 2500,
  parameter int CNT_W       = 19,
  parameter int STAGGER_CYC = 1000
) (
  input  logic                      i_Clk,
  input  logic                      clr_n,
  input  logic                      i_Enable,
  input  logic [NUM_CH*ANGLE_W-1:0] i_Angle,
  input  logic [NUM_CH-1:0]         i_Load,
  output logic [NUM_CH-1:0]         o_Pwm,
  output logic                      o_Frame_Start,
  output logic                      o_Busy
);

`ifdef SERVO_STAGGER_EN
  localparam int STAGGER_ON = 1;
  if ((NUM_CH - 1) * STAGGER_CYC + MAX_PULSE > PERIOD_CYC) begin : g_stagger_overflow
    $error("servo_pwm_array: staggered pulse window exceeds the frame");
  end
`else
  localparam int STAGGER_ON = 0;
`endif

  localparam logic [CNT_W:0]   MIN_W    = (CNT_W+1)'(MIN_PULSE);
  localparam logic [CNT_W:0]   MAX_W    = (CNT_W+1)'(MAX_PULSE);
  localparam logic [CNT_W:0]   LSB_W    = (CNT_W+1)'(PULSE_LSB);
  localparam logic [CNT_W-1:0] STEP_W   = CNT_W'(SLEW_STEP);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CENTER   = CNT_W'(MIN_PULSE + (2 ** (ANGLE_W - 1)) * PULSE_LSB);

  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic [CNT_W-1:0] target [NUM_CH];
  logic [CNT_W-1:0] cur    [NUM_CH];
  logic [NUM_CH-1:0] pwm_next;
  logic [NUM_CH-1:0] mismatch;
  logic [CNT_W:0]    lo;
  logic              boundary;

  assign boundary = (cnt == LAST_CNT);

  // One spare bit keeps the product from wrapping before the clamp.
  function automatic logic [CNT_W-1:0] code_to_width(input logic [ANGLE_W-1:0] code);
    logic [CNT_W:0] raw;
    raw = MIN_W + (CNT_W+1)'(code) * LSB_W;
    if (raw > MAX_W) raw = MAX_W;
    return raw[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] now, input logic [CNT_W-1:0] goal);
    logic [CNT_W-1:0] next;
    next = goal;
    if (SLEW_STEP != 0) begin
      if (goal > now) begin
        if (goal - now > STEP_W) next = now + STEP_W;
      end else begin
        if (now - goal > STEP_W) next = now - STEP_W;
      end
    end
    return next;
  endfunction

  always_comb begin
    pwm_next = '0;
    mismatch = '0;
    lo       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lo          = (CNT_W+1)'(k * STAGGER_CYC * STAGGER_ON);
      pwm_next[k] = en_q && ({1'b0, cnt} >= lo) && ({1'b0, cnt} < lo + {1'b0, cur[k]});
      mismatch[k] = (cur[k] != target[k]);
    end
  end

  // cur and en_q only move on the boundary edge, so a frame never sees a partial update.
  always_ff @(posedge i_Clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt           <= '0;
      en_q          <= 1'b0;
      o_Pwm         <= '0;
      o_Frame_Start <= 1'b0;
      o_Busy        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        target[k] <= CENTER;
        cur[k]    <= CENTER;
      end
    end else begin
      cnt           <= boundary ? '0 : cnt + CNT_W'(1);
      o_Frame_Start <= (cnt == '0);
      o_Pwm         <= pwm_next;
      o_Busy        <= |mismatch;
      if (boundary) en_q <= i_Enable;
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_Load[k]) target[k] <= code_to_width(i_Angle[k*ANGLE_W +: ANGLE_W]);
        if (boundary) cur[k] <= slew(cur[k], target[k]);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb/tb_servo_pwm_array.sv - frame-level checks of servo_pwm_array against a table and a behavioural model.
module tb_servo_pwm_array;
  localparam int NUM_CH  = 4;
  localparam int ANGLE_W = 8;
  localparam int PERIOD  = 1000;
  localparam int MIN_P   = 100;
  localparam int MAX_P   = 400;
  localparam int LSB     = 2;
  localparam int STEP    = 50;
  localparam int CNT_W   = 10;
  localparam int STAGGER = 150;
  localparam int CENTER  = MIN_P + 128 * LSB;
`ifdef SERVO_STAGGER_EN
  localparam int OFFS = STAGGER;
`else
  localparam int OFFS = 0;
`endif

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] angle = '0;
  logic [3:0]  load = '0;
  logic [3:0]  pwm;
  logic        fs;
  logic        busy;

  servo_pwm_array #(
    .NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .PERIOD_CYC(PERIOD), .MIN_PULSE(MIN_P),
    .MAX_PULSE(MAX_P), .PULSE_LSB(LSB), .SLEW_STEP(STEP), .CNT_W(CNT_W), .STAGGER_CYC(STAGGER)
  ) dut (
    .i_Clk(clk), .clr_n(clr_n), .i_Enable(en), .i_Angle(angle), .i_Load(load),
    .o_Pwm(pwm), .o_Frame_Start(fs), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  int m_cur [4];
  int m_tgt [4];
  bit m_en;

  int meas_w [4];
  int meas_first [4];
  int meas_fs;
  int meas_busy;

  typedef struct {
    int          act;
    logic [3:0]  lmask;
    logic [31:0] angs;
    logic        en_val;
    int          w [4];
    bit          busy;
  } vec_t;
  vec_t vt [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int a2w(input int a);
    int w;
    w = MIN_P + a * LSB;
    return (w > MAX_P) ? MAX_P : w;
  endfunction

  function automatic int slew_to(input int c, input int t);
    if (STEP == 0) return t;
    if (t - c > STEP) return c + STEP;
    if (c - t > STEP) return c - STEP;
    return t;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = 0;
    for (int k = 0; k < 4; k++) if (m_cur[k] != m_tgt[k]) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    m_en = 0;
    for (int k = 0; k < 4; k++) begin
      m_cur[k] = CENTER;
      m_tgt[k] = CENTER;
    end
  endtask

  task automatic model_load(input logic [3:0] lmask, input logic [31:0] angs);
    for (int k = 0; k < 4; k++) if (lmask[k]) m_tgt[k] = a2w(int'(angs[k*8 +: 8]));
  endtask

  task automatic model_boundary(input logic en_val);
    m_en = en_val;
    for (int k = 0; k < 4; k++) m_cur[k] = slew_to(m_cur[k], m_tgt[k]);
  endtask

  // Sample index i is the i-th cycle after o_Frame_Start rises; inputs driven at index act hit the edge that ends it.
  task automatic run_frame(input int act, input logic [3:0] lmask, input logic [31:0] angs, input logic en_val);
    int guard;
    guard = 0;
    @(negedge clk);
    while (fs !== 1'b1 && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    check("frame_start_seen", int'(fs), 1);
    meas_busy = int'(busy);
    meas_fs = 0;
    for (int k = 0; k < 4; k++) begin
      meas_w[k] = 0;
      meas_first[k] = -1;
    end
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (pwm[k] === 1'b1) begin
          if (meas_first[k] < 0) meas_first[k] = i;
          meas_w[k]++;
        end
      end
      if (fs === 1'b1) meas_fs++;
      if (i == act) begin
        load = lmask;
        angle = angs;
        en = en_val;
      end else if (i == act + 1) begin
        load = '0;
      end
    end
  endtask

  task automatic do_frame(input string tag, input int act, input logic [3:0] lmask, input logic [31:0] angs,
                          input logic en_val, input int ew [4], input bit eb);
    run_frame(act, lmask, angs, en_val);
    check($sformatf("%s_fs_count", tag), meas_fs, 1);
    check($sformatf("%s_busy", tag), meas_busy, int'(eb));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_width_ch%0d", tag, k), meas_w[k], ew[k]);
      if (ew[k] > 0) check($sformatf("%s_rise_ch%0d", tag, k), meas_first[k], k * OFFS);
    end
    if (act == PERIOD - 2) begin
      model_boundary(en_val);
      model_load(lmask, angs);
    end else begin
      model_load(lmask, angs);
      model_boundary(en_val);
    end
  endtask

  task automatic set_vec(input int i, input int act, input logic [3:0] lmask, input logic [31:0] angs,
                         input logic en_val, input int w0, input int w1, input int w2, input int w3, input bit b);
    vt[i].act = act;
    vt[i].lmask = lmask;
    vt[i].angs = angs;
    vt[i].en_val = en_val;
    vt[i].w[0] = w0;
    vt[i].w[1] = w1;
    vt[i].w[2] = w2;
    vt[i].w[3] = w3;
    vt[i].busy = b;
  endtask

  initial begin
    int ew [4];
    int exp_pwm;
    int act;
    logic [3:0] lm;
    logic [31:0] an;
    logic ev;

    // Widths seen in each frame; the action in the same row lands during that frame.
    set_vec(0,  500, 4'b0000, 32'h0000_0000, 1'b1,   0,   0,   0,   0, 0);
    set_vec(1,  100, 4'b0001, 32'h0000_0000, 1'b1, 356, 356, 356, 356, 0);
    set_vec(2,    0, 4'b0000, 32'h0000_0000, 1'b1, 306, 356, 356, 356, 1);
    set_vec(3,    0, 4'b0000, 32'h0000_0000, 1'b1, 256, 356, 356, 356, 1);
    set_vec(4,    0, 4'b0000, 32'h0000_0000, 1'b1, 206, 356, 356, 356, 1);
    set_vec(5,    0, 4'b0000, 32'h0000_0000, 1'b1, 156, 356, 356, 356, 1);
    set_vec(6,  300, 4'b0110, 32'h0014_FF00, 1'b1, 106, 356, 356, 356, 1);
    set_vec(7,    0, 4'b0000, 32'h0000_0000, 1'b1, 100, 400, 306, 356, 1);
    set_vec(8,    0, 4'b0000, 32'h0000_0000, 1'b1, 100, 400, 256, 356, 1);
    set_vec(9,    0, 4'b0000, 32'h0000_0000, 1'b1, 100, 400, 206, 356, 1);
    set_vec(10,  50, 4'b0000, 32'h0000_0000, 1'b0, 100, 400, 156, 356, 1);
    set_vec(11, 500, 4'b0000, 32'h0000_0000, 1'b1,   0,   0,   0,   0, 0);
    set_vec(12, 998, 4'b1000, 32'h9600_0000, 1'b1, 100, 400, 140, 356, 0);
    set_vec(13,   0, 4'b0000, 32'h0000_0000, 1'b1, 100, 400, 140, 356, 1);
    set_vec(14,   0, 4'b0000, 32'h0000_0000, 1'b1, 100, 400, 140, 400, 0);

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_frame_start", int'(fs), 0);
    check("reset_busy", int'(busy), 0);
    clr_n = 1'b1;

    for (int i = 0; i < 15; i++)
      do_frame($sformatf("vec%0d", i), vt[i].act, vt[i].lmask, vt[i].angs, vt[i].en_val, vt[i].w, vt[i].busy);

    // Reset asserted in the middle of a running pulse.
    @(negedge clk);
    for (int g = 0; g < 2 * PERIOD && fs !== 1'b1; g++) @(negedge clk);
    repeat (20) @(negedge clk);
    exp_pwm = 0;
    for (int k = 0; k < 4; k++)
      if (m_en && 20 >= k * OFFS && 20 < k * OFFS + m_cur[k]) exp_pwm |= (1 << k);
    check("pre_reset_pwm", int'(pwm), exp_pwm);
    clr_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_frame_start", int'(fs), 0);
    check("async_reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("held_reset_pwm", int'(pwm), 0);
    clr_n = 1'b1;
    model_reset();

    for (int f = 0; f < 22; f++) begin
      if (f < 2) begin
        act = 400;
        lm = '0;
        an = '0;
        ev = 1'b1;
      end else begin
        act = ($urandom_range(0, 4) == 0) ? PERIOD - 2 : int'($urandom_range(0, PERIOD - 3));
        lm = 4'($urandom_range(0, 15));
        an = $urandom;
        ev = ($urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 4; k++) ew[k] = m_en ? m_cur[k] : 0;
      do_frame($sformatf("rnd%0d", f), act, lm, an, ev, ew, model_busy());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
